cam_frame_writer: RTL
=====================

# cam_frame_writer

Writer side of the camera frame buffer. Takes the synchronized camera byte stream (8-bit bus, href/vsync levels, one-cycle byte strobe), pairs bytes into RGB565 pixels, and issues single-port BRAM writes into a 240x320 frame buffer. The display-side scaler reads pixels back out of this same buffer. Clipping, row/column tracking and frame framing all live here, so the buffer only ever holds whole, aligned frames.

## Interface
Parameters:
- H_PIXELS, 240, columns stored per row; pixels at column >= H_PIXELS are dropped
- V_PIXELS, 320, rows stored per frame; rows >= V_PIXELS are dropped
- ADDR_WIDTH, 17, frame buffer address width; must satisfy 2^ADDR_WIDTH >= H_PIXELS*V_PIXELS

Ports:
- clk_in  input  1  system clock; the only clock
- rst_n_in  input  1  asynchronous, active-low reset
- byte_valid_in  input  1  one-cycle strobe: byte_in holds a new camera byte
- byte_in  input  8  camera data byte
- href_in  input  1  line-active level, already synchronized to clk_in
- vsync_in  input  1  frame sync level, already synchronized; high = vertical blank
- wr_en_out  output  1  frame buffer write enable, one cycle per stored pixel
- wr_addr_out  output  ADDR_WIDTH  write address = row*H_PIXELS + col
- wr_data_out  output  16  RGB565 pixel {first byte, second byte}
- col_out  output  11  column of the most recent write
- row_out  output  10  row of the most recent write
- frame_done_out  output  1  one-cycle pulse when a frame ends
- frame_count_out  output  8  completed frames, wraps 255 -> 0

## Operation
- States: SYNC, IDLE, LINE.
- SYNC: wait for a vsync_in falling edge, then go to IDLE. Nothing is written in SYNC.
- IDLE (between lines):
  - href_in rising edge -> LINE, with col=0 and byte phase=0.
- LINE:
  - A byte is accepted only when byte_valid_in=1 and href_in=1.
  - Phase 0: latch the byte as the high byte, set phase=1.
  - Phase 1: form the pixel, set phase=0. If col < H_PIXELS and row < V_PIXELS, issue a write. col increments on every completed pixel, saturating at 2047.
  - href_in falling edge -> IDLE. row increments (saturating at 1023) and row_base += H_PIXELS. row_base is held when row >= V_PIXELS.
  - A dangling phase-1 high byte at href fall is discarded.
- Address generation: wr_addr_out = row_base + col. No multiplier; row_base is a running register.
- Edge detection uses one registered copy of href_in and of vsync_in. The registered copies reset to 0.
- vsync_in rising edge, in IDLE or LINE:
  - pulse frame_done_out, increment frame_count_out, go to SYNC.
  - clear row, row_base, col and phase.
  - a partially assembled pixel is discarded.
- vsync_in rising edge while in SYNC: no pulse, no count change.
- Priority within one cycle: vsync rising > href edge > byte accept.
  - A byte strobed in the same cycle as an href falling edge is still accepted if href_in=1 in that cycle.
  - Otherwise it is ignored.
- Short lines (fewer than H_PIXELS pixels) leave the remaining buffer words untouched. The next row still starts at row_base + H_PIXELS.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - state=SYNC; all outputs 0.
  - internal col, row, row_base, phase and edge registers are 0.
- Write latency: the phase-1 byte accepted in cycle N gives wr_en_out=1 in cycle N+1. wr_addr_out, wr_data_out, col_out and row_out are valid in that same cycle.
- wr_en_out is high for exactly one cycle per stored pixel. When low, wr_addr_out, wr_data_out, col_out and row_out hold their last values.
- frame_done_out is high in the cycle after the vsync rising edge is detected, for exactly one cycle. frame_count_out updates in the same cycle.
- Throughput: one byte per cycle. Back-to-back strobes give a write every second cycle.
- Reset asserted mid-line: the immediate return to reset values takes precedence. The first frame after reset requires a vsync fall before any write.

## Test plan
- Reset, then vsync 1->0, one href line of 480 bytes 0x00..0xDF repeating -> 240 writes at addresses 0..239. First data is 0x0001, col_out counts 0..239, row_out=0.
- Line of 600 bytes (300 pixels) -> exactly 240 writes. Next line starts at address 240.
- Full frame of 321 lines x 240 pixels -> writes for rows 0..319 only, last address 76799. vsync rise gives one frame_done_out pulse and frame_count_out=1.
- Odd byte count (5 bytes) at href fall -> 2 writes. The 5th byte is discarded. The next line's first pixel pairs correctly.
- vsync rises mid-line after 3 bytes -> 1 write, frame_done_out pulse, state SYNC. Bytes with href high before the next vsync fall produce no writes.
- rst_n_in pulsed low mid-line -> outputs 0 within the same cycle. 256 complete frames later, frame_count_out wraps to 0.

Source files
------------

// File: rtl/cam_frame_writer.sv
// Camera writer: pairs synchronized camera bytes into RGB565 pixels and writes whole,
// aligned frames into a H_PIXELS x V_PIXELS single-port frame buffer.
//
// state | meaning
// SYNC  | waiting for vsync to fall; nothing is written
// IDLE  | inside a frame, between lines
// LINE  | href active, bytes are being paired into pixels
module cam_frame_writer #(
  parameter int H_PIXELS   = 240,
  parameter int V_PIXELS   = 320,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  byte_valid_in,
  input  logic [7:0]            byte_in,
  input  logic                  href_in,
  input  logic                  vsync_in,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [15:0]           wr_data_out,
  output logic [10:0]           col_out,
  output logic [9:0]            row_out,
  output logic                  frame_done_out,
  output logic [7:0]            frame_count_out
);

  localparam logic [10:0]           COL_LIM  = 11'(H_PIXELS);
  localparam logic [9:0]            ROW_LIM  = 10'(V_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(H_PIXELS);

  typedef enum logic [1:0] {SYNC, IDLE, LINE} state_t;

  state_t                  state, state_nxt;
  logic                    href_q, vsync_q;
  logic                    href_rise, href_fall, vsync_rise, vsync_fall;
  logic                    frame_end, line_start, line_end, accept;
  logic [10:0]             col;
  logic [9:0]              row;
  logic [ADDR_WIDTH-1:0]   row_base;
  logic                    phase;
  logic [7:0]              hi_byte;

  assign href_rise  =  href_in  & ~href_q;
  assign href_fall  = ~href_in  &  href_q;
  assign vsync_rise =  vsync_in & ~vsync_q;
  assign vsync_fall = ~vsync_in &  vsync_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= SYNC;
    else           state <= state_nxt;
  end

  // Priority: vsync rise, then href edge, then byte accept.
  always_comb begin
    state_nxt  = state;
    frame_end  = 1'b0;
    line_start = 1'b0;
    line_end   = 1'b0;
    accept     = 1'b0;
    case (state)
      SYNC: begin
        if (vsync_fall) state_nxt = IDLE;
      end
      IDLE: begin
        if (vsync_rise) begin
          frame_end = 1'b1;
          state_nxt = SYNC;
        end else if (href_rise) begin
          line_start = 1'b1;
          state_nxt  = LINE;
        end
      end
      LINE: begin
        if (vsync_rise) begin
          frame_end = 1'b1;
          state_nxt = SYNC;
        end else if (href_fall) begin
          line_end  = 1'b1;
          state_nxt = IDLE;
        end else if (byte_valid_in && href_in) begin
          accept = 1'b1;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      href_q          <= 1'b0;
      vsync_q         <= 1'b0;
      col             <= '0;
      row             <= '0;
      row_base        <= '0;
      phase           <= 1'b0;
      hi_byte         <= '0;
      wr_en_out       <= 1'b0;
      wr_addr_out     <= '0;
      wr_data_out     <= '0;
      col_out         <= '0;
      row_out         <= '0;
      frame_done_out  <= 1'b0;
      frame_count_out <= '0;
    end else begin
      href_q         <= href_in;
      vsync_q        <= vsync_in;
      wr_en_out      <= 1'b0;
      frame_done_out <= 1'b0;
      if (frame_end) begin
        frame_done_out  <= 1'b1;
        frame_count_out <= frame_count_out + 8'd1;
        col             <= '0;
        row             <= '0;
        row_base        <= '0;
        phase           <= 1'b0;
      end else if (line_start) begin
        col   <= '0;
        phase <= 1'b0;
      end else if (line_end) begin
        // A dangling high byte is simply dropped by clearing the phase.
        phase <= 1'b0;
        if (row != 10'h3FF) row <= row + 10'd1;
        if (row < ROW_LIM)  row_base <= row_base + ROW_STEP;
      end else if (accept) begin
        if (!phase) begin
          hi_byte <= byte_in;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (col != 11'h7FF) col <= col + 11'd1;
          if (col < COL_LIM && row < ROW_LIM) begin
            wr_en_out   <= 1'b1;
            wr_addr_out <= row_base + ADDR_WIDTH'(col);
            wr_data_out <= {hi_byte, byte_in};
            col_out     <= col;
            row_out     <= row;
          end
        end
      end
    end
  end

endmodule
